stopwatch_sportsman_sche: RTL and testbench

Reaction-time stopwatch for a sprint start. The judge's start signal arms and starts a millisecond counter. The sportsman's button stops it. A press before the start is flagged as a foul, and no press within 9.999 s is flagged as a timeout. The elapsed time drives a 4-digit multiplexed 7-segment display as X.XXX seconds. The block sits at board top level, driven by the 50 MHz board clock, and exposes prescaler debug taps.

---
 rtl/stopwatch_sportsman_sche_if.sv | 12 +
 rtl/stopwatch_sportsman_sche.sv | 169 ++++++++++++++++
 tb/tb_stopwatch_sportsman_sche.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/stopwatch_sportsman_sche_if.sv
// Judge/sportsman inputs and the flag + 7-segment display outputs of the sprint stopwatch.
interface stopwatch_sportsman_sche_if;
  logic       judge;
  logic       sportsman;
  logic       timeout;
  logic       foul;
  logic [7:0] sm_duan;
  logic [3:0] sm_wei;

  modport master (output judge, sportsman, input timeout, foul, sm_duan, sm_wei);
  modport slave  (input judge, sportsman, output timeout, foul, sm_duan, sm_wei);
endinterface

// File: rtl/stopwatch_sportsman_sche.sv
// Sprint reaction-time stopwatch: ms BCD counter started by judge, stopped by sportsman,
// with foul/timeout flags and a 4-digit multiplexed common-anode display (X.XXX s).
module stopwatch_sportsman_sche #(
  parameter int TICK_DIV  = 50000,
  parameter int MAX_COUNT = 9999
) (
  input  logic clk_50MHz,
  input  logic reset,
  stopwatch_sportsman_sche_if.slave sw,
  output logic CE0,
  output logic clk,
  output logic data0,
  output logic data1,
  output logic data2,
  output logic data3,
  output logic data4,
  output logic data7,
  output logic data9,
  output logic data12
);

  localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);
  localparam logic [3:0][3:0] MAX_BCD = {4'((MAX_COUNT / 1000) % 10), 4'((MAX_COUNT / 100) % 10),
                                         4'((MAX_COUNT / 10) % 10),   4'(MAX_COUNT % 10)};

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_STOP, S_FOUL, S_TIMEOUT} state_t;

  logic [15:0]     pre;
  logic            tick;
  logic [2:0]      j_sync, s_sync;
  logic            j_rise, j_fall, s_rise;
  state_t          state, state_nxt;
  logic [3:0][3:0] digit, digit_nxt, digit_inc;
  logic            carry;
  logic            foul_q, timeout_q;
  logic [1:0]      scan;
  logic            clk_q;
  logic [3:0]      cur_digit;

  // prescaler
  assign tick = (pre == TICK_LAST);

  always_ff @(posedge clk_50MHz or negedge reset) begin
    if (!reset)    pre <= '0;
    else if (tick) pre <= '0;
    else           pre <= pre + 16'd1;
  end

  // bit0/1 are the 2-flop synchronizer, bit2 holds the previous synced value for edge detect
  always_ff @(posedge clk_50MHz or negedge reset) begin
    if (!reset) begin
      j_sync <= '0;
      s_sync <= '0;
    end else begin
      j_sync <= {j_sync[1:0], sw.judge};
      s_sync <= {s_sync[1:0], sw.sportsman};
    end
  end

  assign j_rise = j_sync[1] & ~j_sync[2];
  assign j_fall = ~j_sync[1] & j_sync[2];
  assign s_rise = s_sync[1] & ~s_sync[2];

  // ripple-carry BCD increment, each digit wraps 9 -> 0
  always_comb begin
    digit_inc = digit;
    carry     = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (digit[i] == 4'd9) begin
          digit_inc[i] = 4'd0;
        end else begin
          digit_inc[i] = digit[i] + 4'd1;
          carry        = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_50MHz or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      digit     <= '0;
      foul_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      digit     <= digit_nxt;
      foul_q    <= (state_nxt == S_FOUL);
      timeout_q <= (state_nxt == S_TIMEOUT);
    end
  end

  // a press always wins over a judge edge or a tick in the same cycle
  always_comb begin
    state_nxt = state;
    digit_nxt = digit;
    case (state)
      S_IDLE: begin
        digit_nxt = '0;
        if (s_rise)      state_nxt = S_FOUL;
        else if (j_rise) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (s_rise) begin
          state_nxt = S_STOP;
        end else if (tick) begin
          digit_nxt = digit_inc;
          if (digit_inc == MAX_BCD) state_nxt = S_TIMEOUT;
        end
      end
      S_STOP, S_FOUL, S_TIMEOUT: begin
        if (j_fall) begin
          state_nxt = S_IDLE;
          digit_nxt = '0;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        digit_nxt = '0;
      end
    endcase
  end

  // display scan and tick-rate square wave
  always_ff @(posedge clk_50MHz or negedge reset) begin
    if (!reset) begin
      scan  <= 2'd0;
      clk_q <= 1'b0;
    end else if (tick) begin
      scan  <= scan + 2'd1;
      clk_q <= ~clk_q;
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  assign cur_digit  = digit[scan];
  assign sw.sm_duan = {(scan != 2'd3), seg7(cur_digit)};
  assign sw.sm_wei  = ~(4'b0001 << scan);
  assign sw.foul    = foul_q;
  assign sw.timeout = timeout_q;

  assign CE0    = tick && (state == S_RUN);
  assign clk    = clk_q;
  assign data0  = pre[0];
  assign data1  = pre[1];
  assign data2  = pre[2];
  assign data3  = pre[3];
  assign data4  = pre[4];
  assign data7  = pre[7];
  assign data9  = pre[9];
  assign data12 = pre[12];

endmodule

// File: tb/tb_stopwatch_sportsman_sche.sv
// Randomized bench for the sprint stopwatch against an integer-millisecond reference model.
module tb_stopwatch_sportsman_sche;
  localparam int TD   = 6;
  localparam int MAXC = 9999;
  localparam int M_IDLE = 0, M_RUN = 1, M_STOP = 2, M_FOUL = 3, M_TO = 4;

  logic clk_50MHz = 1'b0;
  logic reset     = 1'b0;
  logic CE0, clk, data0, data1, data2, data3, data4, data7, data9, data12;

  always #5 clk_50MHz = ~clk_50MHz;

  stopwatch_sportsman_sche_if intf ();

  stopwatch_sportsman_sche #(.TICK_DIV(TD), .MAX_COUNT(MAXC)) dut (
    .clk_50MHz(clk_50MHz), .reset(reset), .sw(intf),
    .CE0(CE0), .clk(clk),
    .data0(data0), .data1(data1), .data2(data2), .data3(data3),
    .data4(data4), .data7(data7), .data9(data9), .data12(data12)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // reference model: elapsed time as a plain integer of milliseconds
  int         m_pre = 0, m_ms = 0, m_scan = 0, m_state = M_IDLE;
  bit         m_clk = 0;
  logic [2:0] jh = '0, sh = '0;
  logic [7:0] seg_code [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
  int         pow10 [4] = '{1, 10, 100, 1000};

  always @(posedge clk_50MHz or negedge reset) begin
    if (!reset) begin
      m_pre <= 0; m_ms <= 0; m_scan <= 0; m_state <= M_IDLE; m_clk <= 0;
      jh <= '0; sh <= '0;
    end else begin : step
      bit tick, jr, jf, sr;
      int ns, nms;
      tick = (m_pre == TD - 1);
      // inputs seen at edge m reach the edge detector two edges later
      jr = jh[1] & ~jh[2];
      jf = ~jh[1] & jh[2];
      sr = sh[1] & ~sh[2];
      ns = m_state; nms = m_ms;
      case (m_state)
        M_IDLE: begin nms = 0; if (sr) ns = M_FOUL; else if (jr) ns = M_RUN; end
        M_RUN:  if (sr) ns = M_STOP;
                else if (tick) begin nms = m_ms + 1; if (nms == MAXC) ns = M_TO; end
        default: if (jf) begin ns = M_IDLE; nms = 0; end
      endcase
      m_state <= ns;
      m_ms    <= nms;
      m_pre   <= tick ? 0 : m_pre + 1;
      if (tick) begin m_scan <= (m_scan + 1) % 4; m_clk <= !m_clk; end
      jh <= {jh[1:0], intf.judge};
      sh <= {sh[1:0], intf.sportsman};
    end
  end

  function automatic logic [31:0] exp_outs();
    int d; logic [7:0] du; logic [3:0] w; logic ce; logic [15:0] pv;
    d  = (m_ms / pow10[m_scan]) % 10;
    du = seg_code[d];
    if (m_scan == 3) du[7] = 1'b0;
    w = 4'b1111; w[m_scan] = 1'b0;
    ce = (m_pre == TD - 1) && (m_state == M_RUN);
    pv = m_pre[15:0];
    return {8'h0, m_state == M_TO, m_state == M_FOUL, ce, m_clk, w, du,
            pv[12], pv[9], pv[7], pv[4], pv[3], pv[2], pv[1], pv[0]};
  endfunction

  function automatic logic [31:0] act_outs();
    return {8'h0, intf.timeout, intf.foul, CE0, clk, intf.sm_wei, intf.sm_duan,
            data12, data9, data7, data4, data3, data2, data1, data0};
  endfunction

  always @(negedge clk_50MHz) chk("outs", act_outs(), exp_outs());

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_50MHz);
  endtask

  // capture one full scan frame, indexed by enabled digit
  task automatic show(output logic [3:0][7:0] d);
    d = '0;
    for (int i = 0; i < 4 * TD; i++) begin
      @(negedge clk_50MHz);
      case (intf.sm_wei)
        4'b1110: d[0] = intf.sm_duan;
        4'b1101: d[1] = intf.sm_duan;
        4'b1011: d[2] = intf.sm_duan;
        4'b0111: d[3] = intf.sm_duan;
        default: ;
      endcase
    end
  endtask

  task automatic press();
    intf.sportsman = 1'b1;
    cyc($urandom_range(1, 4));
    intf.sportsman = 1'b0;
  endtask

  logic [3:0][7:0] disp;
  logic [3:0]      w;
  int n, bound, t0, t1;

  initial begin
    intf.judge = 1'b0;
    intf.sportsman = 1'b0;
    cyc(100);
    chk("rst_wei",   intf.sm_wei, 4'b1110);
    chk("rst_duan",  intf.sm_duan, 8'hC0);
    chk("rst_flags", {intf.timeout, intf.foul, CE0, clk}, 4'b0000);
    reset = 1'b1;

    // idle scan walks the digits once per tick
    for (int k = 0; k < 4; k++) begin
      w = 4'b1111; w[k] = 1'b0;
      chk("idle_wei", intf.sm_wei, w);
      chk("idle_duan", intf.sm_duan, (k == 3) ? 8'h40 : 8'hC0);
      cyc(TD);
    end

    // directed 0.123 run
    intf.judge = 1'b1;
    n = 0; bound = 0; t0 = 0; t1 = 0;
    while (n < 123 && bound < 2000) begin
      @(negedge clk_50MHz);
      bound++;
      if (CE0) begin
        n++;
        if (n == 1) t0 = bound;
        if (n == 2) t1 = bound;
      end
    end
    chk("run_ticks", n, 123);
    chk("ce0_period", t1 - t0, TD);
    intf.sportsman = 1'b1;
    cyc(5);
    intf.sportsman = 1'b0;
    cyc(2 * TD);
    show(disp);
    chk("stop_d3", disp[3], 8'h40);
    chk("stop_d2", disp[2], 8'hF9);
    chk("stop_d1", disp[1], 8'hA4);
    chk("stop_d0", disp[0], 8'hB0);
    chk("stop_flags", {intf.timeout, intf.foul}, 2'b00);
    intf.judge = 1'b0;
    cyc(8);

    // false start
    intf.sportsman = 1'b1;
    cyc(3);
    chk("foul_set", {intf.timeout, intf.foul}, 2'b01);
    intf.sportsman = 1'b0;
    intf.judge = 1'b1;
    cyc(10);
    chk("foul_hold", {intf.timeout, intf.foul}, 2'b01);
    show(disp);
    chk("foul_disp", disp, {8'h40, 8'hC0, 8'hC0, 8'hC0});
    intf.judge = 1'b0;
    cyc(6);
    chk("foul_clr", intf.foul, 1'b0);

    // random rounds: idle gap, then either a false start or a timed run
    for (int r = 0; r < 8; r++) begin
      cyc($urandom_range(0, 20));
      if ($urandom_range(0, 3) == 0) begin
        press();
        cyc(5);
        intf.judge = 1'b1;
        cyc($urandom_range(1, 10));
      end else begin
        intf.judge = 1'b1;
        cyc($urandom_range(1, 150) * TD + $urandom_range(0, TD - 1));
        press();
        cyc($urandom_range(5, 12));
        press();
        cyc(4 * TD);
      end
      intf.judge = 1'b0;
      cyc(6);
      chk("round_idle", {intf.timeout, intf.foul}, 2'b00);
    end

    // no press: timeout at terminal count
    intf.judge = 1'b1;
    bound = 0;
    while (!intf.timeout && bound < (MAXC + 10) * TD) begin
      @(negedge clk_50MHz);
      bound++;
    end
    chk("timeout_seen", intf.timeout, 1'b1);
    chk("timeout_foul", intf.foul, 1'b0);
    show(disp);
    chk("timeout_disp", disp, {8'h10, 8'h90, 8'h90, 8'h90});
    n = 0;
    for (int i = 0; i < 3 * TD; i++) begin
      @(negedge clk_50MHz);
      if (CE0) n++;
    end
    chk("timeout_ce0", n, 0);
    press();
    cyc(6);
    chk("timeout_ignore", {intf.timeout, intf.foul}, 2'b10);
    intf.judge = 1'b0;
    cyc(6);

    // asynchronous reset in the middle of a run
    intf.judge = 1'b1;
    cyc(20 * TD + 3);
    #2 reset = 1'b0;
    #1;
    chk("arst_wei",   intf.sm_wei, 4'b1110);
    chk("arst_duan",  intf.sm_duan, 8'hC0);
    chk("arst_flags", {intf.timeout, intf.foul, CE0, clk}, 4'b0000);
    chk("arst_taps",  {data12, data9, data7, data4, data3, data2, data1, data0}, 8'h00);
    intf.judge = 1'b0;
    cyc(5);
    reset = 1'b1;
    cyc(3 * TD);
    show(disp);
    chk("post_rst_disp", disp, {8'h40, 8'hC0, 8'hC0, 8'hC0});
    chk("post_rst_state", m_state, M_IDLE);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
